// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: round-robin write-back arbiter feeding an in-order register file write queue
// Optional feature macro: WB_BYPASS_EN builds the forwarding lookup; otherwise byp_hit/byp_data are tied 0.
// Ports: in_pkt/in_valid/in_ready  per-channel {is_write, addr, value} requests
//        rf_stall/rf_we/rf_addr/rf_data  register file write port (drains the queue head)
//        byp_addr/byp_hit/byp_data  lookup of the youngest queued write to an address
//        count  current queue occupancy
module regfile_writeback_queue #(
    parameter int DW     = 64,
    parameter int AW     = 4,
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH*(1+AW+DW)-1:0] in_pkt,
    input  logic [NUM_CH-1:0]           in_valid,
    output logic [NUM_CH-1:0]           in_ready,
    input  logic                        rf_stall,
    output logic                        rf_we,
    output logic [AW-1:0]               rf_addr,
    output logic [DW-1:0]               rf_data,
    input  logic [AW-1:0]               byp_addr,
    output logic                        byp_hit,
    output logic [DW-1:0]               byp_data,
    output logic [$clog2(DEPTH+1)-1:0]  count
);
    localparam int W  = 1 + AW + DW;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [AW+DW-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [GW-1:0]    arb_ptr_q, arb_ptr_d, gnt_idx, scan;
    logic             gnt_any, gnt_wr, accept, push, pop;
    logic [W-1:0]     pkt [NUM_CH];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) pkt[c] = in_pkt[c*W +: W];
    end

    // Walk channels from the round-robin pointer, wrapping; first valid one wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = arb_ptr_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!gnt_any && in_valid[scan]) begin
                gnt_any = 1'b1;
                gnt_idx = scan;
            end
            scan = (scan == GW'(NUM_CH - 1)) ? '0 : scan + 1'b1;
        end
    end

    assign rf_we     = (count_q != '0) && !rf_stall;
    assign pop       = rf_we;
    assign gnt_wr    = pkt[gnt_idx][W-1];
    // A full queue still accepts a write when the head leaves this cycle; reset blocks any handshake.
    assign accept    = rst_n && gnt_any && (!gnt_wr || count_q < CW'(DEPTH) || pop);
    assign push      = accept && gnt_wr;
    assign count_d   = count_q + CW'(push) - CW'(pop);
    assign arb_ptr_d = accept ? ((gnt_idx == GW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1) : arb_ptr_q;
    assign count     = count_q;
    assign rf_addr   = (count_q == '0) ? '0 : mem_q[rd_ptr_q][AW+DW-1:DW];
    assign rf_data   = (count_q == '0) ? '0 : mem_q[rd_ptr_q][DW-1:0];

    always_comb begin
        in_ready = '0;
        if (accept) in_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            arb_ptr_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_q + PW'(pop);
            wr_ptr_q  <= wr_ptr_q + PW'(push);
            count_q   <= count_d;
            arb_ptr_q <= arb_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= pkt[gnt_idx][AW+DW-1:0];
    end

`ifdef WB_BYPASS_EN
    logic [PW-1:0] byp_idx;

    // Scan oldest to youngest so the last match (youngest write) wins.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        byp_idx  = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count_q && mem_q[byp_idx][AW+DW-1:DW] == byp_addr) begin
                byp_hit  = 1'b1;
                byp_data = mem_q[byp_idx][DW-1:0];
            end
            byp_idx = byp_idx + 1'b1;
        end
    end
`else
    logic unused_byp;
    assign unused_byp = ^byp_addr;
    assign byp_hit    = 1'b0;
    assign byp_data   = '0;
`endif
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb_regfile_writeback_queue: scoreboard bench for regfile_writeback_queue
module tb_regfile_writeback_queue;
    localparam int DW = 64, AW = 4, NUM_CH = 2, DEPTH = 4, W = 1 + AW + DW;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0, rst_n = 1'b0, rf_stall = 1'b0;
    logic [NUM_CH*W-1:0] in_pkt = '0;
    logic [NUM_CH-1:0] in_valid = '0, in_ready;
    logic              rf_we, byp_hit;
    logic [AW-1:0]     rf_addr, byp_addr = '0;
    logic [DW-1:0]     rf_data, byp_data;
    logic [2:0]        count;
    int                checks = 0, failures = 0;
    logic [AW+DW-1:0]  exp_q [$];
    logic [AW+DW-1:0]  mon_e;

    always #5 clk = ~clk;

    regfile_writeback_queue #(.DW(DW), .AW(AW), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_pkt(in_pkt), .in_valid(in_valid), .in_ready(in_ready),
        .rf_stall(rf_stall), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .byp_addr(byp_addr), .byp_hit(byp_hit), .byp_data(byp_data), .count(count)
    );

    function automatic logic [W-1:0] mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] v);
        return {w, a, v};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every register file write must match the next expected write in order.
    initial forever begin
        @(negedge clk);
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", rf_addr, rf_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("mon_rf_addr", 64'(rf_addr), 64'(mon_e[AW+DW-1:DW]));
                chk("mon_rf_data", rf_data, mon_e[DW-1:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 2'b11;
        in_pkt   = {mk(1'b1, 4'd1, 64'd1), mk(1'b1, 4'd2, 64'd2)};
        @(negedge clk);
        @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_rf_addr", 64'(rf_addr), 64'd0);
        chk("rst_rf_data", rf_data, 64'd0);
        chk("rst_byp_hit", 64'(byp_hit), 64'd0);
        cyc;
        in_valid = '0;
        rst_n    = 1'b1;

        // Single write
        cyc;
        in_pkt[0 +: W] = mk(1'b1, 4'd6, 64'd50);
        in_valid = 2'b01;
        exp_q.push_back({4'd6, 64'd50});
        @(negedge clk);
        chk("single_ready", 64'(in_ready), 64'd1);
        chk("single_we_same_cycle", 64'(rf_we), 64'd0);
        cyc;
        in_valid = '0;
        @(negedge clk);
        chk("single_count", 64'(count), 64'd1);
        chk("single_we", 64'(rf_we), 64'd1);
        cyc;
        @(negedge clk);
        chk("single_count_after", 64'(count), 64'd0);

        // Discard
        cyc;
        in_pkt[W +: W] = mk(1'b0, 4'd3, 64'd25);
        in_valid = 2'b10;
        @(negedge clk);
        chk("discard_ready", 64'(in_ready), 64'd2);
        chk("discard_we", 64'(rf_we), 64'd0);
        cyc;
        in_valid = '0;
        @(negedge clk);
        chk("discard_count", 64'(count), 64'd0);
        chk("discard_we_after", 64'(rf_we), 64'd0);

        // Round-robin: grants 0,1,0,1
        exp_q.push_back({4'd1, 64'd100});
        exp_q.push_back({4'd9, 64'd900});
        exp_q.push_back({4'd2, 64'd200});
        exp_q.push_back({4'd10, 64'd1000});
        for (int i = 0; i < 4; i++) begin
            cyc;
            in_pkt = {mk(1'b1, i < 2 ? 4'd9 : 4'd10, i < 2 ? 64'd900 : 64'd1000),
                      mk(1'b1, i < 1 ? 4'd1 : 4'd2, i < 1 ? 64'd100 : 64'd200)};
            in_valid = {1'b1, i < 3};
            @(negedge clk);
            chk("rr_ready", 64'(in_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
        end
        cyc;
        in_valid = '0;
        repeat (3) @(negedge clk);
        chk("rr_count_drained", 64'(count), 64'd0);

        // Full with stall, then push+pop on release
        for (int i = 0; i < 4; i++) begin
            cyc;
            rf_stall = 1'b1;
            in_pkt[0 +: W] = mk(1'b1, 4'(11 + i), 64'(32'h1100 + i));
            in_valid = 2'b01;
            exp_q.push_back({4'(11 + i), 64'(32'h1100 + i)});
            @(negedge clk);
            chk("fill_ready", 64'(in_ready), 64'd1);
        end
        cyc;
        in_pkt[0 +: W] = mk(1'b1, 4'd15, 64'h1500);
        @(negedge clk);
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(in_ready), 64'd0);
        chk("full_we", 64'(rf_we), 64'd0);
        cyc;
        rf_stall = 1'b0;
        exp_q.push_back({4'd15, 64'h1500});
        @(negedge clk);
        chk("release_ready", 64'(in_ready), 64'd1);
        chk("release_we", 64'(rf_we), 64'd1);
        chk("release_count", 64'(count), 64'd4);
        cyc;
        in_valid = '0;
        @(negedge clk);
        chk("pushpop_count", 64'(count), 64'd4);
        repeat (5) @(negedge clk);
        chk("full_drained", 64'(count), 64'd0);

        // Bypass: youngest matching write wins
        cyc;
        rf_stall = 1'b1;
        in_pkt[0 +: W] = mk(1'b1, 4'd5, 64'd10);
        in_valid = 2'b01;
        @(negedge clk);
        chk("byp_push1_ready", 64'(in_ready), 64'd1);
        cyc;
        in_pkt[0 +: W] = mk(1'b1, 4'd5, 64'd20);
        @(negedge clk);
        chk("byp_push2_ready", 64'(in_ready), 64'd1);
        cyc;
        in_valid = '0;
        byp_addr = 4'd5;
        @(negedge clk);
        chk("byp_count", 64'(count), 64'd2);
        chk("byp_hit5", 64'(byp_hit), 64'(BYP));
        chk("byp_data5", byp_data, BYP ? 64'd20 : 64'd0);
        cyc;
        byp_addr = 4'd7;
        @(negedge clk);
        chk("byp_hit7", 64'(byp_hit), 64'd0);
        chk("byp_data7", byp_data, 64'd0);
        cyc;
        byp_addr = 4'd5;
        rf_stall = 1'b0;
        exp_q.push_back({4'd5, 64'd10});
        exp_q.push_back({4'd5, 64'd20});
        @(negedge clk);
        chk("byp_hit_popping", 64'(byp_hit), 64'(BYP));
        chk("byp_data_popping", byp_data, BYP ? 64'd20 : 64'd0);
        repeat (3) @(negedge clk);
        chk("byp_drained", 64'(count), 64'd0);

        // Reset mid-operation with three queued writes
        for (int i = 0; i < 3; i++) begin
            cyc;
            rf_stall = 1'b1;
            in_pkt[0 +: W] = mk(1'b1, 4'(2 + i), 64'(i + 7));
            in_valid = 2'b01;
        end
        cyc;
        in_valid = '0;
        @(negedge clk);
        chk("mid_count", 64'(count), 64'd3);
        #1;
        in_pkt[0 +: W] = mk(1'b1, 4'd8, 64'd8);
        in_valid = 2'b01;
        #1;
        chk("mid_ready_pre", 64'(in_ready), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_we", 64'(rf_we), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_addr", 64'(rf_addr), 64'd0);
        in_valid = '0;
        rf_stall = 1'b0;
        cyc;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_count", 64'(count), 64'd0);
        chk("exp_all_seen", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
